// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_pkg
// Description : Shared types for the regfile write-port arbiter: word,
//               address, instruction and register-index types, the writeback
//               request record and the grant FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 64;
    localparam int INST_W     = 32;

    typedef logic [WORD_W-1:0]     word_t;
    typedef logic [WORD_W-1:0]     addr_t;
    typedef logic [INST_W-1:0]     inst_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr;

    // One retiring instruction as seen by the regfile and commit interface.
    typedef struct packed {
        logic    we;
        reg_addr rd;
        word_t   data;
        addr_t   pc;
        inst_t   inst;
    } wb_req_t;

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } grant_state_t;

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_md_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : md_result_fifo
// Description : Synchronous FIFO of wb_req_t records holding multi-cycle
//               results until they win the regfile write port.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               i_push/i_data   - enqueue a record (caller guarantees !o_full)
//               i_pop/o_head    - dequeue / head record (valid when !o_empty)
//               o_count         - occupancy, o_full / o_empty flags
// Revision    : 1.0 - initial release
// ============================================================================
module md_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  wb_req_t                    i_data,
    input  logic                       i_pop,
    output wb_req_t                    o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_req_t            r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the single regfile write port between the pipeline
//               writeback stage and buffered mul/div results. The pipeline
//               has priority; a non-empty result FIFO denied STARVE_LIMIT
//               consecutive cycles is forced through for one cycle.
//               Regfile write and commit outputs are registered (1 cycle
//               after grant).
// Ports       : clk, reset              - clock, synchronous active-high reset
//               i_wb_* / o_wb_ready     - pipeline WB request / accept
//               i_md_* / o_md_ready     - multi-cycle result / FIFO accept
//               o_rf_*                  - registered regfile write
//               o_commit_*              - registered retire (difftest) info
//               o_buf_count             - FIFO occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_wb_valid,
    input  logic                        i_wb_we,
    input  logic [4:0]                  i_wb_rd,
    input  logic [63:0]                 i_wb_data,
    input  logic [63:0]                 i_wb_pc,
    input  logic [31:0]                 i_wb_inst,
    output logic                        o_wb_ready,
    input  logic                        i_md_valid,
    input  logic [4:0]                  i_md_rd,
    input  logic [63:0]                 i_md_data,
    input  logic [63:0]                 i_md_pc,
    input  logic [31:0]                 i_md_inst,
    output logic                        o_md_ready,
    output logic                        o_rf_we,
    output logic [4:0]                  o_rf_addr,
    output logic [63:0]                 o_rf_data,
    output logic                        o_commit_valid,
    output logic [63:0]                 o_commit_pc,
    output logic [31:0]                 o_commit_inst,
    output logic [$clog2(BUF_DEPTH):0]  o_buf_count
);

    localparam int      SC_W      = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [SC_W-1:0] C_STARVE_MAX = SC_W'(STARVE_LIMIT - 1);

    wb_req_t        w_md_req;
    wb_req_t        w_head;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic           w_grant_md;
    logic           w_grant_wb;

    grant_state_t   r_state;
    logic [SC_W-1:0] r_starve_cnt;

    // FIFO entries always write their rd.
    assign w_md_req = '{we: 1'b1, rd: i_md_rd, data: i_md_data,
                        pc: i_md_pc, inst: i_md_inst};

    // Ready comes from registered occupancy only: a full FIFO refuses even
    // when it is being popped this cycle.
    assign o_md_ready = !w_full;
    assign w_push     = i_md_valid && !w_full;

    // FORCE is only entered with a non-empty FIFO that was not popped, so
    // the head is valid whenever r_state == FORCE.
    assign w_grant_md = (r_state == FORCE) || (!w_empty && !i_wb_valid);
    assign w_grant_wb = !w_grant_md && i_wb_valid;
    assign w_pop      = w_grant_md;
    assign o_wb_ready = !w_grant_md;

    md_result_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_md_req),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (o_buf_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= NORMAL;
            r_starve_cnt   <= '0;
            o_rf_we        <= 1'b0;
            o_rf_addr      <= '0;
            o_rf_data      <= '0;
            o_commit_valid <= 1'b0;
            o_commit_pc    <= '0;
            o_commit_inst  <= '0;
        end else begin
            case (r_state)
                NORMAL: begin
                    if (!w_empty && !w_grant_md && r_starve_cnt == C_STARVE_MAX) begin
                        r_state <= FORCE;
                    end
                end
                FORCE:   r_state <= NORMAL;
                default: r_state <= NORMAL;
            endcase

            if (w_pop || w_empty) begin
                r_starve_cnt <= '0;
            end else if (r_starve_cnt != C_STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            // Unselected fields hold; only the strobes drop when idle.
            if (w_grant_md) begin
                o_rf_we        <= w_head.we && (w_head.rd != '0);
                o_rf_addr      <= w_head.rd;
                o_rf_data      <= w_head.data;
                o_commit_valid <= 1'b1;
                o_commit_pc    <= w_head.pc;
                o_commit_inst  <= w_head.inst;
            end else if (w_grant_wb) begin
                o_rf_we        <= i_wb_we && (i_wb_rd != '0);
                o_rf_addr      <= i_wb_rd;
                o_rf_data      <= i_wb_data;
                o_commit_valid <= 1'b1;
                o_commit_pc    <= i_wb_pc;
                o_commit_inst  <= i_wb_inst;
            end else begin
                o_rf_we        <= 1'b0;
                o_commit_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Self-checking bench for wb_port_arbiter: directed scenarios
//               with literal expectations, then randomized traffic compared
//               every cycle against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    typedef struct {
        bit          we;
        bit [4:0]    rd;
        bit [63:0]   data;
        bit [63:0]   pc;
        bit [31:0]   inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data, wb_pc;
    logic [31:0] wb_inst;
    logic        wb_ready;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [63:0] md_data, md_pc;
    logic [31:0] md_inst;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [63:0] rf_data;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [31:0] commit_inst;
    logic [$clog2(DEPTH):0] buf_count;

    wb_port_arbiter #(
        .BUF_DEPTH    (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_wb_valid     (wb_valid),
        .i_wb_we        (wb_we),
        .i_wb_rd        (wb_rd),
        .i_wb_data      (wb_data),
        .i_wb_pc        (wb_pc),
        .i_wb_inst      (wb_inst),
        .o_wb_ready     (wb_ready),
        .i_md_valid     (md_valid),
        .i_md_rd        (md_rd),
        .i_md_data      (md_data),
        .i_md_pc        (md_pc),
        .i_md_inst      (md_inst),
        .o_md_ready     (md_ready),
        .o_rf_we        (rf_we),
        .o_rf_addr      (rf_addr),
        .o_rf_data      (rf_data),
        .o_commit_valid (commit_valid),
        .o_commit_pc    (commit_pc),
        .o_commit_inst  (commit_inst),
        .o_buf_count    (buf_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    ent_t        q[$];
    int          denied;      // consecutive cycles the non-empty FIFO lost
    bit          force_due;   // FIFO owns the port this cycle unconditionally
    bit          e_rf_we, e_cv;
    bit [4:0]    e_addr;
    bit [63:0]   e_data, e_pc;
    bit [31:0]   e_inst;
    bit          last_wb_taken;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic retire(input ent_t e);
        e_rf_we = e.we && (e.rd != 0);
        e_addr  = e.rd;
        e_data  = e.data;
        e_cv    = 1'b1;
        e_pc    = e.pc;
        e_inst  = e.inst;
    endtask

    // One clock: check handshakes mid-cycle, advance model, check registered
    // outputs just after the edge. Inputs must already be driven.
    task automatic cycle();
        bit   mdr, gmd, push;
        ent_t e;
        #2;
        if (reset) begin
            q.delete();
            denied = 0; force_due = 0;
            e_rf_we = 0; e_cv = 0; e_addr = 0; e_data = 0; e_pc = 0; e_inst = 0;
            last_wb_taken = 1;
        end else begin
            mdr  = (q.size() < DEPTH);
            gmd  = force_due || (q.size() > 0 && !wb_valid);
            push = md_valid && mdr;
            chk("md_ready", md_ready, mdr);
            chk("wb_ready", wb_ready, !gmd);
            last_wb_taken = !(wb_valid && gmd);
            if (gmd) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL model_grant_empty: got 0 entries expected >0 at %0t", $time);
                end else begin
                    retire(q.pop_front());
                end
                force_due = 0;
                denied = 0;
            end else begin
                if (wb_valid) begin
                    e.we = wb_we; e.rd = wb_rd; e.data = wb_data; e.pc = wb_pc; e.inst = wb_inst;
                    retire(e);
                end else begin
                    e_rf_we = 0; e_cv = 0;
                end
                if (q.size() > 0) begin
                    if (denied == LIMIT - 1) force_due = 1;
                    else denied++;
                end else begin
                    denied = 0;
                end
            end
            if (push) begin
                e.we = 1; e.rd = md_rd; e.data = md_data; e.pc = md_pc; e.inst = md_inst;
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("rf_we", rf_we, e_rf_we);
        chk("rf_addr", rf_addr, e_addr);
        chk("rf_data", rf_data, e_data);
        chk("commit_valid", commit_valid, e_cv);
        chk("commit_pc", commit_pc, e_pc);
        chk("commit_inst", commit_inst, e_inst);
        chk("buf_count", buf_count, q.size());
    endtask

    task automatic set_wb(input bit v, input bit we, input bit [4:0] rd,
                          input bit [63:0] d, input bit [63:0] pc, input bit [31:0] in);
        wb_valid = v; wb_we = we; wb_rd = rd; wb_data = d; wb_pc = pc; wb_inst = in;
    endtask

    task automatic set_md(input bit v, input bit [4:0] rd, input bit [63:0] d,
                          input bit [63:0] pc, input bit [31:0] in);
        md_valid = v; md_rd = rd; md_data = d; md_pc = pc; md_inst = in;
    endtask

    initial begin
        int n;
        reset = 1;
        set_wb(0, 0, 0, 0, 0, 0);
        set_md(1, 5'd3, 64'h55, 64'h100, 32'h13);
        @(posedge clk); #1;

        // Reset held 2 cycles with md_valid asserted: nothing captured.
        cycle();
        cycle();
        chk("rst_rf_we", rf_we, 0);
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_commit_pc", commit_pc, 0);
        chk("rst_buf_count", buf_count, 0);
        reset = 0;
        set_md(0, 0, 0, 0, 0);

        // Pipeline write with empty FIFO.
        set_wb(1, 1, 5'd5, 64'h1234, 64'h8000_0000, 32'h0000_0293);
        cycle();
        chk("p_rf_we", rf_we, 1);
        chk("p_rf_addr", rf_addr, 5);
        chk("p_rf_data", rf_data, 64'h1234);
        chk("p_commit_pc", commit_pc, 64'h8000_0000);
        set_wb(0, 0, 0, 0, 0, 0);

        // Single multi-cycle result, idle pipeline: latency 2.
        set_md(1, 5'd7, 64'hAA, 64'h8000_0010, 32'h0220_03b3);
        cycle();
        chk("m_count1", buf_count, 1);
        chk("m_no_commit_yet", commit_valid, 0);
        set_md(0, 0, 0, 0, 0);
        cycle();
        chk("m_rf_addr", rf_addr, 7);
        chk("m_rf_data", rf_data, 64'hAA);
        chk("m_count0", buf_count, 0);

        // Starvation: one buffered entry behind a continuous pipeline.
        set_md(1, 5'd9, 64'hBEEF, 64'h8000_0020, 32'h0);
        set_wb(1, 1, 5'd1, 64'h10, 64'h8000_0030, 32'h1);
        cycle();
        set_md(0, 0, 0, 0, 0);
        for (int i = 0; i < LIMIT; i++) begin
            set_wb(1, 1, 5'd1, 64'h11 + i, 64'h8000_0034 + 4 * i, 32'h1);
            #2; chk("s_wb_ready_hi", wb_ready, 1); #(-0);
            cycle();
        end
        set_wb(1, 1, 5'd2, 64'h77, 64'h8000_0044, 32'h2);
        cycle();
        chk("s_forced_addr", rf_addr, 9);
        chk("s_forced_data", rf_data, 64'hBEEF);
        cycle();
        chk("s_resume_addr", rf_addr, 2);
        chk("s_resume_data", rf_data, 64'h77);

        // Fill the FIFO behind the pipeline; third result waits for space.
        for (int i = 0; i < 2; i++) begin
            set_md(1, 5'(10 + i), 64'h200 + i, 64'h9000_0000 + 4 * i, 32'h3);
            set_wb(1, 1, 5'd4, 64'h300 + i, 64'hA000_0000 + 4 * i, 32'h4);
            cycle();
        end
        chk("f_count_full", buf_count, 2);
        set_md(1, 5'd12, 64'h202, 64'h9000_0008, 32'h3);
        n = 0;
        while (n < 20) begin
            set_wb(1, 1, 5'd4, 64'h400 + n, 64'hA000_0100 + 4 * n, 32'h4);
            #2;
            if (md_ready) begin
                #(-0);
                cycle();
                break;
            end
            cycle();
            n++;
        end
        if (n >= 20) chk("f_accept_timeout", 1, 0);
        set_md(0, 0, 0, 0, 0);
        set_wb(0, 0, 0, 0, 0, 0);
        n = 0;
        while (q.size() > 0 && n < 20) begin
            cycle();
            n++;
        end
        chk("f_drained", buf_count, 0);

        // Write to x0 still commits but does not write.
        set_wb(1, 1, 5'd0, 64'hFF, 64'h8000_0100, 32'h0ff0_0013);
        cycle();
        chk("z_rf_we", rf_we, 0);
        chk("z_commit_valid", commit_valid, 1);
        set_wb(0, 0, 0, 0, 0, 0);

        // Randomized traffic; an unaccepted pipeline instruction is held.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (last_wb_taken || reset)
                set_wb(($urandom_range(0, 9) < 6), $urandom_range(0, 1),
                       5'($urandom_range(0, 31)), {$urandom, $urandom},
                       {$urandom, $urandom}, $urandom);
            set_md(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)),
                   {$urandom, $urandom}, {$urandom, $urandom}, $urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
